out_port_uart_tx: RTL

Serial transmitter for the CPU's output port. It captures every byte the CPU writes to its OUT register, using the same load strobe and bus value, and queues it in a small FIFO. It then sends each byte LSB-first as an 8N1 UART frame on a single pin. It sits beside the CPU at top level so program output reaches a host terminal without stalling the CPU.

---
 rtl/out_port_uart_tx_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/out_port_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/out_port_uart_tx_pkg.sv
// Shared definitions for the CPU output-port UART transmitter.
// The tx_state_t encoding always includes PARITY so that state values
// stay identical whether or not the parity option is built.
package out_port_uart_tx_pkg;

    // Width of the CPU output register, shared with the rest of the datapath.
    localparam int DATA_WIDTH = 8;

    localparam int OUT_TX_CLKS_PER_BIT_DEFAULT = 104;
    localparam int OUT_TX_FIFO_DEPTH_DEFAULT   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fallthrough read data.
// A write on a full FIFO is accepted only when a read happens in the same
// cycle; otherwise it is ignored (the caller decides how to flag that).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted writes only.
    // NOTE: the data array has no reset; only pointers and count define
    // validity, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_uart_tx.sv
// CPU output-port UART transmitter: captures every OUT-register write into a
// small FIFO and sends each byte LSB-first as an 8N1 frame on `tx`.
// Build option: define OUT_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module out_port_uart_tx
    import out_port_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = out_port_uart_tx_pkg::DATA_WIDTH,
    parameter int CLKS_PER_BIT = OUT_TX_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = OUT_TX_FIFO_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);

    tx_state_t             state, state_next;
    logic [TW-1:0]         timer, timer_next;
    logic [IW-1:0]         bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  tx_next;
    logic                  busy_next;
    logic                  bit_done;

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [AW:0]           fifo_count;

`ifdef OUT_TX_PARITY_EN
    logic                  parity_q, parity_next;
`endif

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_done = (timer == TIMER_LAST);

    // Next-state logic; tx/busy are computed one cycle ahead so the line
    // itself comes straight from a flop.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        tx_next      = 1'b1;
        fifo_rd_en   = 1'b0;
`ifdef OUT_TX_PARITY_EN
        parity_next  = parity_q;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en  = 1'b1;
                    shift_next  = fifo_rd_data;
`ifdef OUT_TX_PARITY_EN
                    parity_next = ^fifo_rd_data;
`endif
                    timer_next  = '0;
                    state_next  = START;
                    tx_next     = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                end else begin
                    timer_next   = timer + 1'b1;
                    tx_next      = 1'b0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_next = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_idx == IDX_LAST) begin
`ifdef OUT_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_q;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shift_next[0];
                    end
                end else begin
                    timer_next = timer + 1'b1;
                    tx_next    = shift_reg[0];
                end
            end
`ifdef OUT_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    timer_next = '0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                    tx_next    = parity_q;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                timer_next = '0;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // Frame state, registered line outputs and the sticky drop flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            busy      <= busy_next;
            if (wr_en && fifo_full && !fifo_rd_en) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef OUT_TX_PARITY_EN
    // Parity of the byte being sent, latched when it is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_next;
        end
    end
`endif

    // Occupancy can never exceed the configured depth.
    assert property (@(posedge clk) disable iff (reset) fifo_count <= DEPTH_CNT);

endmodule
